// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester (CPU, DMA) arbiter in front of a single-port
// 64K x 8 memory. Registered ownership, fixed CPU priority, a DMA starvation
// override after MAX_WAIT cycles, and per-requester bus lock.
// Optional grant statistics are built only when ARB_STATS_EN is defined.
module mem_bus_arbiter #(
   parameter int MAX_WAIT = 4
`ifdef ARB_STATS_EN
   ,
   parameter int STAT_W   = 16
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_lock,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_gnt,
   input  logic        dma_req,
   input  logic        dma_lock,
   input  logic [15:0] dma_addr,
   input  logic        dma_we,
   input  logic [7:0]  dma_wdata,
   output logic        dma_gnt,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  rdata
`ifdef ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] cpu_grant_count,
   output logic [STAT_W-1:0] dma_grant_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CPU  = 2'd1,
      S_DMA  = 2'd2
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_wait_cnt;
   logic [7:0]  w_wait_next;
   logic        w_owner_hold;
   logic        w_owner_req;

   // Owner keeps the bus only while it both requests and locks
   assign w_owner_hold = ((r_state == S_CPU) && cpu_req && cpu_lock) ||
                         ((r_state == S_DMA) && dma_req && dma_lock);

   // Next-owner selection: lock, then starvation/idle-CPU DMA, then CPU, then DMA
   always_comb begin
      w_state_next = S_IDLE;
      if (w_owner_hold)
         w_state_next = r_state;
      else if (dma_req && (!cpu_req || (r_wait_cnt >= MAX_WAIT_C)))
         w_state_next = S_DMA;
      else if (cpu_req)
         w_state_next = S_CPU;
      else if (dma_req)
         w_state_next = S_DMA;

      // DMA wait time only accumulates while DMA is pending and not about to win
      if (!dma_req || (w_state_next == S_DMA))
         w_wait_next = 8'd0;
      else if (r_wait_cnt >= MAX_WAIT_C)
         w_wait_next = MAX_WAIT_C;
      else
         w_wait_next = r_wait_cnt + 8'd1;
   end

   // Ownership and starvation counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_next;
      end
   end

   assign cpu_gnt = (r_state == S_CPU);
   assign dma_gnt = (r_state == S_DMA);

   // Route the owner's bus to memory; an idle bus presents all zeros
   always_comb begin
      mem_addr    = 16'd0;
      mem_wdata   = 8'd0;
      mem_we      = 1'b0;
      w_owner_req = 1'b0;
      case (r_state)
         S_CPU: begin
            mem_addr    = cpu_addr;
            mem_wdata   = cpu_wdata;
            mem_we      = cpu_req & cpu_we;
            w_owner_req = cpu_req;
         end
         S_DMA: begin
            mem_addr    = dma_addr;
            mem_wdata   = dma_wdata;
            mem_we      = dma_req & dma_we;
            w_owner_req = dma_req;
         end
         default: ;
      endcase
   end

   assign rdata = mem_rdata;

`ifdef ARB_STATS_EN
   logic [1:0]        w_xfer;
   logic [STAT_W-1:0] r_cnt [2];

   assign w_xfer[0] = cpu_gnt & w_owner_req;
   assign w_xfer[1] = dma_gnt & w_owner_req;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_stat
         // Count completed transfers for requester gi (wraps naturally)
         always_ff @(posedge clock or posedge reset) begin
            if (reset)
               r_cnt[gi] <= '0;
            else if (w_xfer[gi])
               r_cnt[gi] <= r_cnt[gi] + 1'b1;
         end
      end
   endgenerate

   assign cpu_grant_count = r_cnt[0];
   assign dma_grant_count = r_cnt[1];
`else
   // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
module tb_mem_bus_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int STAT_W   = 16;
   localparam int OWN_NONE = 0;
   localparam int OWN_CPU  = 1;
   localparam int OWN_DMA  = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_lock = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = 16'd0;
   logic [7:0]  cpu_wdata = 8'd0;
   logic        dma_req = 1'b0, dma_lock = 1'b0, dma_we = 1'b0;
   logic [15:0] dma_addr = 16'd0;
   logic [7:0]  dma_wdata = 8'd0;
   logic        cpu_gnt, dma_gnt, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata, rdata;
`ifdef ARB_STATS_EN
   logic [STAT_W-1:0] cpu_grant_count, dma_grant_count;
`endif

   always #5 clock = ~clock;

   mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
      .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
      .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr),
      .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .rdata(rdata)
`ifdef ARB_STATS_EN
      , .cpu_grant_count(cpu_grant_count), .dma_grant_count(dma_grant_count)
`endif
   );

   // Environment memory: combinational read, write on posedge
   logic [7:0] mem     [65536];
   logic [7:0] ref_mem [65536];
   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'(i) ^ 8'hA5;
         ref_mem[i] = 8'(i) ^ 8'hA5;
      end
   end
   always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   typedef struct {
      int          cyc;
      logic        cg, dg, we, xfer;
      logic [15:0] a;
      logic [7:0]  wd, rd;
      logic [STAT_W-1:0] cc, dc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Behavioural model state
   int                m_owner = OWN_NONE;
   int                m_wait  = 0;
   logic [STAT_W-1:0] m_ccnt  = '0;
   logic [STAT_W-1:0] m_dcnt  = '0;
   int                cyc_n   = 0;

   // One bus cycle: drive inputs, predict this cycle's outputs, advance the model
   task automatic cyc(input logic rst,
                      input logic cr, input logic cl, input logic [15:0] ca,
                      input logic cw, input logic [7:0] cd,
                      input logic dr, input logic dl, input logic [15:0] da,
                      input logic dw, input logic [7:0] dd);
      exp_t e;
      int   nxt, nw;
      logic oreq;
      @(negedge clock);
      reset = rst;
      cpu_req = cr; cpu_lock = cl; cpu_addr = ca; cpu_we = cw; cpu_wdata = cd;
      dma_req = dr; dma_lock = dl; dma_addr = da; dma_we = dw; dma_wdata = dd;
      if (rst) begin
         m_owner = OWN_NONE; m_wait = 0; m_ccnt = '0; m_dcnt = '0;
      end
      e.cyc = cyc_n;
      e.cg  = (m_owner == OWN_CPU);
      e.dg  = (m_owner == OWN_DMA);
      oreq  = (m_owner == OWN_CPU) ? cr : (m_owner == OWN_DMA) ? dr : 1'b0;
      e.a   = (m_owner == OWN_CPU) ? ca : (m_owner == OWN_DMA) ? da : 16'd0;
      e.wd  = (m_owner == OWN_CPU) ? cd : (m_owner == OWN_DMA) ? dd : 8'd0;
      e.we  = oreq & ((m_owner == OWN_CPU) ? cw : dw);
      e.xfer = oreq;
      e.rd  = ref_mem[e.a];
      e.cc  = m_ccnt;
      e.dc  = m_dcnt;
      exp_q.push_back(e);
      // Arbitration rules, first match wins
      if (rst)                                                        nxt = OWN_NONE;
      else if ((m_owner == OWN_CPU && cr && cl) ||
               (m_owner == OWN_DMA && dr && dl))                      nxt = m_owner;
      else if (dr && (!cr || m_wait >= MAX_WAIT))                     nxt = OWN_DMA;
      else if (cr)                                                    nxt = OWN_CPU;
      else if (dr)                                                    nxt = OWN_DMA;
      else                                                            nxt = OWN_NONE;
      if (rst || !dr || nxt == OWN_DMA) nw = 0;
      else nw = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      @(posedge clock);
      if (!rst) begin
         if (e.we) ref_mem[e.a] = e.wd;
         if (e.xfer && e.cg) m_ccnt = m_ccnt + 1'b1;
         if (e.xfer && e.dg) m_dcnt = m_dcnt + 1'b1;
      end
      m_owner = nxt;
      m_wait  = nw;
      cyc_n++;
   endtask

   task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, req);
      end
   endtask

   // Monitor: compare settled DUT outputs against the queued prediction
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cpu_gnt",   e.cyc, 16'(cpu_gnt),   16'(e.cg));
            chk("dma_gnt",   e.cyc, 16'(dma_gnt),   16'(e.dg));
            chk("mem_we",    e.cyc, 16'(mem_we),    16'(e.we));
            chk("mem_addr",  e.cyc, mem_addr,       e.a);
            chk("mem_wdata", e.cyc, 16'(mem_wdata), 16'(e.wd));
            chk("rdata",     e.cyc, 16'(rdata),     16'(e.rd));
`ifdef ARB_STATS_EN
            chk("cpu_grant_count", e.cyc, 16'(cpu_grant_count), 16'(e.cc));
            chk("dma_grant_count", e.cyc, 16'(dma_grant_count), 16'(e.dc));
`endif
            if (e.xfer)
               $display("xfer cyc=%0d owner=%s op=%s addr=%h wdata=%h rdata=%h",
                        e.cyc, e.cg ? "CPU" : "DMA", e.we ? "WR" : "RD", e.a, e.wd, e.rd);
         end
      end
   end

   initial begin
      logic        r, cr, cl, cw, dr, dl, dw;
      logic [15:0] ca, da;
      logic [7:0]  cd, dd;
      // Reset held over two edges with both requesting, then CPU wins from idle
      cyc(1, 1,0,16'h0000,0,8'h00, 1,0,16'h0000,0,8'h00);
      cyc(1, 1,0,16'h0000,0,8'h00, 1,0,16'h0000,0,8'h00);
      cyc(0, 1,0,16'h0000,0,8'h00, 1,0,16'h0000,0,8'h00);
      cyc(0, 1,0,16'h0000,0,8'h00, 1,0,16'h0000,0,8'h00);
      // CPU write then read back
      cyc(0, 1,0,16'h0200,1,8'h5A, 0,0,16'h0000,0,8'h00);
      cyc(0, 1,0,16'h0200,1,8'h5A, 0,0,16'h0000,0,8'h00);
      cyc(0, 1,0,16'h0200,0,8'h00, 0,0,16'h0000,0,8'h00);
      // Starvation: DMA pending while CPU keeps requesting
      for (int i = 0; i < 6; i++) cyc(0, 1,0,16'h0201,0,8'h00, 1,0,16'h0300,1,8'hC3);
      cyc(0, 1,0,16'h0201,0,8'h00, 0,0,16'h0300,0,8'h00);
      cyc(0, 1,0,16'h0300,0,8'h00, 0,0,16'h0000,0,8'h00);
      // DMA lock against a requesting CPU
      cyc(0, 0,0,16'h0000,0,8'h00, 1,0,16'h0400,0,8'h00);
      for (int i = 0; i < 10; i++) cyc(0, 1,1,16'h0401,1,8'h11, 1,1,16'h0400+16'(i),1,8'(i));
      cyc(0, 1,0,16'h0401,0,8'h00, 1,0,16'h0405,0,8'h00);
      cyc(0, 1,0,16'h0401,0,8'h00, 0,0,16'h0000,0,8'h00);
      // CPU lock overrides starvation
      for (int i = 0; i < 8; i++) cyc(0, 1,1,16'h0500,1,8'(8'h40+i), 1,0,16'h0501,1,8'h77);
      cyc(0, 1,0,16'h0500,0,8'h00, 1,0,16'h0501,1,8'h77);
      cyc(0, 1,0,16'h0500,0,8'h00, 1,0,16'h0501,1,8'h77);
      // CPU owner drops request with we high; DMA takes over
      cyc(0, 1,0,16'h0600,0,8'h00, 0,0,16'h0000,0,8'h00);
      cyc(0, 0,0,16'h0600,1,8'hEE, 1,0,16'h0601,0,8'h00);
      cyc(0, 0,0,16'h0600,1,8'hEE, 1,0,16'h0601,0,8'h00);
      cyc(0, 0,0,16'h0600,0,8'h00, 0,0,16'h0601,0,8'h00);
      // Random traffic with occasional asynchronous reset
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 59) == 0);
         cr = ($urandom_range(0, 9) < 6);
         cl = ($urandom_range(0, 9) < 3);
         cw = 1'($urandom_range(0, 1));
         dr = ($urandom_range(0, 9) < 5);
         dl = ($urandom_range(0, 9) < 3);
         dw = 1'($urandom_range(0, 1));
         ca = 16'h0200 + 16'($urandom_range(0, 7));
         da = 16'h0200 + 16'($urandom_range(0, 7));
         cd = 8'($urandom);
         dd = 8'($urandom);
         cyc(r, cr,cl,ca,cw,cd, dr,dl,da,dw,dd);
      end
      cyc(0, 0,0,16'h0000,0,8'h00, 0,0,16'h0000,0,8'h00);
      @(negedge clock);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
